serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: sequences one instance of the team's gate-level full-adder cell `fa` (ports x, y, z -> s, c) over WIDTH cycles to add two WIDTH-bit operands.
- Owns the operand and sum shift registers, the carry flip-flop, the bit counter, and a start/done handshake.
- Sits between a register-file or host requester and the shared 1-bit adder cell; trades area for latency.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk, accepted only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  WIDTH  result; held until next accepted start
- cout  output  1  final carry; held until next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry and counter cleared. Reset mid-operation aborts the add with no done pulse.
- States: IDLE, RUN, DONE. Binary encoding; unreachable codes return to IDLE.
- IDLE, start=1 at edge k:
  - a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, state<=RUN.
  - sum and cout are not cleared until the first RUN edge.
- RUN, each edge:
  - fa inputs: x=a_sr[0], y=b_sr[0], z=carry.
  - sum_sr<={s, sum_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by 1.
  - carry<=c, cnt<=cnt+1.
  - When cnt==WIDTH-1: state<=DONE.
  - cnt width is clog2(WIDTH) bits, minimum 1.
- RUN occupies edges k+1..k+WIDTH.
- DONE (registered outputs, set on edge k+WIDTH):
  - done=1 for exactly one cycle.
  - sum=sum_sr value including the final bit; cout=final carry.
  - The next edge returns to IDLE and drops done.
- Latency: done is high in the cycle after edge k+WIDTH, i.e. WIDTH clocks after the start-sampling edge. The earliest next accepted start is the edge at which done is high plus 1 (IDLE).
- start while busy (RUN or DONE): ignored, not queued; operands are not re-captured.
- a, b and cin may change freely after the accepting edge.
- Arithmetic: sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
- WIDTH=1: a single RUN cycle, then DONE.
- busy is combinational from the state register only (glitch-free).

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port `sub` (1 bit), captured with the operands.
  - When sub=1: b_sr loads ~b and carry loads 1 (cin ignored), giving sum = a-b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b unsigned).
  - sub=0 behaves as the plain add.
- Undefined: no `sub` port; add-only behaviour as above.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h5A, cin=0, start pulsed 1 cycle -> done pulses exactly 8 clocks after the start edge; sum=8'h96, cout=0; busy high for 9 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=0, b=0, cin=1 -> sum=8'h01, cout=0. Results are held after done until the next start.
- Start held high continuously with a=8'h10, b=8'h20: second start accepted only after the return to IDLE; operands changed mid-RUN to 8'hAA/8'h55 -> first result 8'h30. Done pulses spaced 10 clocks apart.
- rst_n asserted asynchronously (mid-clock) at RUN bit 4 -> busy, done, sum and cout go to 0 immediately with no done pulse; a subsequent add of 8'h01+8'h01 returns 8'h02.
- WIDTH=1 build: a=1, b=1, cin=1 -> sum=1, cout=1, done 1 clock after the start edge.
- SERIAL_ADD_SUB_EN defined:
  - sub=1, a=8'h10, b=8'h01 -> sum=8'h0F, cout=1.
  - sub=1, a=8'h01, b=8'h02 -> sum=8'hFF, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell, WIDTH clocks per add, start/done handshake.
// Define SERIAL_ADD_SUB_EN to add a `sub` input that turns the operation into a - b.

module fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  logic xy;

  assign xy = x ^ y;
  assign s  = xy ^ z;
  assign c  = (x & y) | (z & xy);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aSr_q;
  logic [WIDTH-1:0] bSr_q;
  logic [WIDTH-1:0] sumSr_q;
  logic [WIDTH-1:0] sumSr_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [WIDTH-1:0] bLoad;
  logic             carryLoad;
  logic             faS;
  logic             faC;

  fa u_fa (
    .x (aSr_q[0]),
    .y (bSr_q[0]),
    .z (carry_q),
    .s (faS),
    .c (faC)
  );

  // Subtraction is a + ~b + 1, so only the operand and carry loads change.
  always_comb begin
    bLoad     = b;
    carryLoad = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      bLoad     = ~b;
      carryLoad = 1'b1;
    end
`endif
  end

  always_comb begin
    sumSr_d          = sumSr_q >> 1;
    sumSr_d[WIDTH-1] = faS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aSr_q   <= '0;
      bSr_q   <= '0;
      sumSr_q <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            aSr_q   <= a;
            bSr_q   <= bLoad;
            carry_q <= carryLoad;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          aSr_q   <= aSr_q >> 1;
          bSr_q   <= bSr_q >> 1;
          sumSr_q <= sumSr_d;
          carry_q <= faC;
          cnt_q   <= cnt_q + CW'(1);
          // Previous result stays visible until the first bit of the new add is computed.
          if (cnt_q == LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            sum_q   <= sumSr_d;
            cout_q  <= faC;
          end else if (cnt_q == '0) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: timeline model checked every cycle plus directed literal cases.
// Exercises SERIAL_ADD_SUB_EN cases only when that macro is defined.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic start1, sub1, a1, b1, cin1, busy1, done1, sum1, cout1;

  int vecCount  = 0;
  int missCount = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub1),
`endif
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs as a function of how many edges have passed since the accepting edge.
  int         edgeCnt;
  int         acceptEdge;
  bit         opActive;
  logic [W:0] expRes;
  logic [W-1:0] heldSum;
  logic       heldCout;

  function automatic bit expBusy();
    if (!opActive) return 1'b0;
    return (edgeCnt - acceptEdge) <= W;
  endfunction

  function automatic bit expDone();
    if (!opActive) return 1'b0;
    return (edgeCnt - acceptEdge) == W;
  endfunction

  function automatic logic [W-1:0] expSum();
    int d;
    if (!opActive) return heldSum;
    d = edgeCnt - acceptEdge;
    if (d == 0) return heldSum;
    if (d < W) return '0;
    return expRes[W-1:0];
  endfunction

  function automatic logic expCout();
    int d;
    if (!opActive) return heldCout;
    d = edgeCnt - acceptEdge;
    if (d == 0) return heldCout;
    if (d < W) return 1'b0;
    return expRes[W];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edgeCnt    <= 0;
      acceptEdge <= 0;
      opActive   <= 1'b0;
      expRes     <= '0;
      heldSum    <= '0;
      heldCout   <= 1'b0;
    end else begin
      edgeCnt <= edgeCnt + 1;
      if (start && (!opActive || (edgeCnt - acceptEdge) >= W + 1)) begin
        opActive   <= 1'b1;
        acceptEdge <= edgeCnt + 1;
        heldSum    <= expSum();
        heldCout   <= expCout();
`ifdef SERIAL_ADD_SUB_EN
        if (sub)
          expRes <= {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else
          expRes <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`else
        expRes <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model busy", {31'd0, busy}, {31'd0, expBusy()});
      checkOutput("model done", {31'd0, done}, {31'd0, expDone()});
      checkOutput("model sum", {24'd0, sum}, {24'd0, expSum()});
      checkOutput("model cout", {31'd0, cout}, {31'd0, expCout()});
    end
  end

  // Pulses start for one edge; returns at the negedge right after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv, input logic sv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    sub   = sv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic sv,
                       input logic [W-1:0] es, input logic ec);
    int lat;
    int busyCnt;
    applyStimulus(av, bv, cv, sv);
    lat     = -1;
    busyCnt = busy ? 1 : 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) begin
        lat = j;
        break;
      end
    end
    checkOutput({name, " latency"}, lat, W);
    checkOutput({name, " sum"}, {24'd0, sum}, {24'd0, es});
    checkOutput({name, " cout"}, {31'd0, cout}, {31'd0, ec});
    @(negedge clk);
    if (!busy) busyCnt = busyCnt;
    checkOutput({name, " busy cycles"}, busyCnt, W + 1);
    checkOutput({name, " done drop"}, {31'd0, done}, 32'd0);
    checkOutput({name, " busy drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d1;
    int d2;
    int lat1;
    rst_n  = 1'b0;
    start  = 1'b0;
    sub    = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    sub1   = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;
    cin1   = 1'b0;
    #1;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset sum", {24'd0, sum}, 32'd0);
    checkOutput("reset cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("3C+5A", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0);
    runOp("FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    runOp("00+00+1", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("held sum", {24'd0, sum}, 32'h01);
    checkOutput("held cout", {31'd0, cout}, 32'd0);

    // Start held high; operands change mid-run and must not affect the first result.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h20;
    cin   = 1'b0;
    d1    = -1;
    d2    = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 3) begin
        a = 8'hAA;
        b = 8'h55;
      end
      if (done) begin
        if (d1 < 0) begin
          d1 = i;
          checkOutput("held-start first sum", {24'd0, sum}, 32'h30);
        end else begin
          d2 = i;
          checkOutput("held-start second sum", {24'd0, sum}, 32'hFF);
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    checkOutput("done spacing", d2 - d1, 10);
    repeat (2) @(negedge clk);

    // Asynchronous abort in the middle of a run.
    applyStimulus(8'h3C, 8'h5A, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort sum", {24'd0, sum}, 32'd0);
    checkOutput("abort cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    checkOutput("abort no done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    runOp("01+01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

    // Single-bit instance: one run cycle then done.
    @(negedge clk);
    start1 = 1'b1;
    a1     = 1'b1;
    b1     = 1'b1;
    cin1   = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat1   = -1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (done1) begin
        lat1 = j;
        break;
      end
    end
    checkOutput("w1 latency", lat1, 1);
    checkOutput("w1 sum", {31'd0, sum1}, 32'd1);
    checkOutput("w1 cout", {31'd0, cout1}, 32'd1);

`ifdef SERIAL_ADD_SUB_EN
    runOp("10-01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    runOp("01-02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
    runOp("sub0 add", 8'h21, 8'h12, 1'b1, 1'b0, 8'h34, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
